// File: rtl/apb_dpcm_feeder.sv
// ---------------------------------------------------------------------------
// apb_dpcm_feeder
//   APB3 slave that feeds CPU-written samples into an external DPCM
//   saturation stage and collects the stage's results for read-back.
//
//   Samples written to DATA_IN are queued in a TX FIFO. They are issued one
//   per cycle on dpcm_in and tracked in a valid shift register that mirrors
//   the stage latency. Results returning on dpcm_out are pushed into an RX
//   FIFO that the CPU drains through DATA_OUT. Issue is throttled so that
//   every in-flight sample is guaranteed a free RX slot.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata            APB3 request
//   prdata, pready,
//   pslverr           APB3 response (zero wait states, error on TX
//                     overflow or RX underflow)
//   dpcm_in           registered sample to the DPCM stage
//   dpcm_out          result from the DPCM stage, DPCM_LAT cycles later
//   irq               level interrupt: RX non-empty and CTRL.IE
//
// Register map (paddr[3:2])
//   0x0 DATA_IN   W push TX          R 0
//   0x4 DATA_OUT  R pop RX           W ignored
//   0x8 STATUS    R flags / counts   W ignored
//   0xC CTRL      RW {FLUSH, IE, EN}, FLUSH self-clears
// ---------------------------------------------------------------------------

// Small synchronous FIFO with extra-MSB pointers. A push is accepted when
// there is room or when a pop in the same cycle frees a slot; a pop is
// accepted whenever the FIFO holds data. clear empties it on the next edge.
module dpcm_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and a resettable array costs real flops.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module apb_dpcm_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int DPCM_LAT   = 2,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        dpcm_in,
    input  logic [7:0]        dpcm_out,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        REG_DATA_IN  = 2'd0,
        REG_DATA_OUT = 2'd1,
        REG_STATUS   = 2'd2,
        REG_CTRL     = 2'd3
    } reg_e;

    reg_e               reg_sel;
    logic               access;
    logic               wr_data_in;
    logic               rd_data_out;
    logic               wr_ctrl;

    logic               ctrl_en;
    logic               ctrl_ie;
    logic               ctrl_flush;

    logic [DPCM_LAT-1:0] valid_pipe;
    logic               busy;
    logic               issue;

    logic [7:0]         tx_rdata;
    logic [PTR_W-1:0]   tx_count;
    logic               tx_empty;
    logic               tx_full;
    logic [7:0]         rx_rdata;
    logic [PTR_W-1:0]   rx_count;
    logic               rx_empty;
    logic               rx_full;
    logic               rx_push;
    logic               rx_pop;

    logic [31:0]        status;
    logic               unused_bits;

    function automatic logic [3:0] sat_count(input logic [PTR_W-1:0] c);
        return (int'(c) > 15) ? 4'hf : 4'(c);
    endfunction

    assign pready      = 1'b1;
    assign access      = psel && penable;
    assign reg_sel     = reg_e'(paddr[3:2]);
    assign wr_data_in  = access &&  pwrite && (reg_sel == REG_DATA_IN);
    assign rd_data_out = access && !pwrite && (reg_sel == REG_DATA_OUT);
    assign wr_ctrl     = access &&  pwrite && (reg_sel == REG_CTRL);
    assign unused_bits = ^{pwdata[31:8], paddr};

    // Issue only if every sample already in RX or in flight, plus this one,
    // still fits in RX. That bound is what makes RX overflow impossible.
    assign busy  = |valid_pipe;
    assign issue = ctrl_en && !ctrl_flush && !tx_empty &&
                   ((int'(rx_count) + $countones(valid_pipe)) < FIFO_DEPTH);

    assign rx_push = valid_pipe[DPCM_LAT-1];
    assign rx_pop  = rd_data_out && !rx_empty;

    dpcm_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (ctrl_flush),
        .push  (wr_data_in),
        .pop   (issue),
        .wdata (pwdata[7:0]),
        .rdata (tx_rdata),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full)
    );

    dpcm_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (ctrl_flush),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (dpcm_out),
        .rdata (rx_rdata),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign status = {19'b0, busy, sat_count(rx_count), sat_count(tx_count),
                     rx_full, rx_empty, tx_full, tx_empty};

    // Read data and error are combinational so they are valid in the same
    // access cycle that pready=1 completes; outside an access both are 0.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            if (pwrite) begin
                // A simultaneous feeder pop frees the slot, so a full TX
                // only errors when nothing leaves it this cycle.
                if (reg_sel == REG_DATA_IN && tx_full && !issue) pslverr = 1'b1;
            end else begin
                unique case (reg_sel)
                    REG_DATA_IN:  prdata = '0;
                    REG_DATA_OUT: begin
                        if (rx_empty) pslverr = 1'b1;
                        else          prdata  = {{24{rx_rdata[7]}}, rx_rdata};
                    end
                    REG_STATUS:   prdata = status;
                    REG_CTRL:     prdata = {29'b0, ctrl_flush, ctrl_ie, ctrl_en};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            ctrl_ie    <= 1'b0;
            ctrl_flush <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en    <= pwdata[0];
            ctrl_ie    <= pwdata[1];
            ctrl_flush <= pwdata[2];
        end else begin
            ctrl_flush <= 1'b0;
        end
    end

    // Valid pipe mirrors the stage latency; the MSB marks the cycle in which
    // dpcm_out carries the result of an issued sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            dpcm_in    <= '0;
            irq        <= 1'b0;
        end else begin
            valid_pipe <= ctrl_flush ? '0 : DPCM_LAT'({valid_pipe, issue});
            if (issue) dpcm_in <= tx_rdata;
            irq <= ctrl_ie && !rx_empty;
        end
    end
endmodule

// File: tb/tb_apb_dpcm_feeder.sv
// ---------------------------------------------------------------------------
// tb_apb_dpcm_feeder
//   Self-checking bench for apb_dpcm_feeder. A behavioural DPCM stage
//   (saturating x2, one register, matching a 2-cycle issue-to-capture
//   latency) sits on dpcm_in/dpcm_out. Accepted DATA_IN writes push the
//   stage's expected result into a scoreboard queue; DATA_OUT reads pop and
//   compare. Register-level expectations are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_apb_dpcm_feeder;
    localparam logic [3:0] A_DATA_IN  = 4'h0;
    localparam logic [3:0] A_DATA_OUT = 4'h4;
    localparam logic [3:0] A_STATUS   = 4'h8;
    localparam logic [3:0] A_CTRL     = 4'hC;

    logic        clk;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  dpcm_in;
    logic [7:0]  dpcm_out;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  sample;
        logic [31:0] result;
    } vec_t;
    vec_t vecs[5];

    apb_dpcm_feeder #(.FIFO_DEPTH(8), .DPCM_LAT(2), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .dpcm_in  (dpcm_in),
        .dpcm_out (dpcm_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DPCM saturation stage.
    function automatic logic [7:0] dpcm_model(input logic [7:0] x);
        int t;
        t = int'($signed(x)) * 2;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    function automatic logic [31:0] sext_model(input logic [7:0] x);
        logic [7:0] m;
        m = dpcm_model(x);
        return {{24{m[7]}}, m};
    endfunction

    initial dpcm_out = 8'h00;
    always @(posedge clk) dpcm_out <= dpcm_model(dpcm_in);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic write_ctrl(input logic [31:0] val);
        logic e;
        apb_write(A_CTRL, val, e);
        check("ctrl write err", {31'b0, e}, 32'd0);
    endtask

    task automatic write_sample(input logic [7:0] s, input logic [31:0] exp_res, input logic exp_err);
        logic e;
        apb_write(A_DATA_IN, {24'b0, s}, e);
        check("data_in err", {31'b0, e}, {31'b0, exp_err});
        if (!exp_err) exp_q.push_back(exp_res);
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_read(A_STATUS, d, e);
        check(name, d, exp);
    endtask

    task automatic read_result(input string name);
        logic [31:0] d;
        logic e;
        apb_read(A_DATA_OUT, d, e);
        check({name, " err"}, {31'b0, e}, 32'd0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected no result queued", name, d);
        end else begin
            check(name, d, exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic        found;

        vecs[0] = '{sample: 8'h05, result: 32'h0000000A};
        vecs[1] = '{sample: 8'h0A, result: 32'h00000014};
        vecs[2] = '{sample: 8'hF0, result: 32'hFFFFFFE0};
        vecs[3] = '{sample: 8'h7F, result: 32'h0000007F};
        vecs[4] = '{sample: 8'h80, result: 32'hFFFFFF80};

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        check("reset prdata",  prdata, 32'd0);
        check("reset pslverr", {31'b0, pslverr}, 32'd0);
        check("reset dpcm_in", {24'b0, dpcm_in}, 32'd0);
        check("reset irq",     {31'b0, irq}, 32'd0);
        check("pready",        {31'b0, pready}, 32'd1);
        reset = 1'b0;
        check_status("reset status", 32'h0000_0005);
        apb_read(A_CTRL, d, e);
        check("reset ctrl", d, 32'd0);
        apb_read(A_DATA_IN, d, e);
        check("data_in read", d, 32'd0);

        // Test 1: queue the table with EN=0, then enable and watch a burst.
        foreach (vecs[i]) write_sample(vecs[i].sample, vecs[i].result, 1'b0);
        check_status("t1 tx queued", 32'h0000_0054);
        write_ctrl(32'h1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (dpcm_in == vecs[0].sample) found = 1'b1;
        end
        check("t1 first issue seen", {31'b0, found}, 32'd1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("t1 dpcm_in burst", {24'b0, dpcm_in}, {24'b0, vecs[k].sample});
        end
        repeat (6) @(negedge clk);
        check_status("t1 rx filled", 32'h0000_0501);
        for (int k = 0; k < 5; k++) read_result("t1 data_out");
        check_status("t1 drained", 32'h0000_0005);

        // Test 2: TX overflow with EN=0.
        write_ctrl(32'h0);
        for (int i = 0; i < 9; i++)
            write_sample(8'h10 + 8'(i), sext_model(8'h10 + 8'(i)), (i == 8));
        check_status("t2 tx full", 32'h0000_0086);

        // Test 3: RX underflow.
        apb_read(A_DATA_OUT, d, e);
        check("t3 underflow err",   {31'b0, e}, 32'd1);
        check("t3 underflow data",  d, 32'd0);
        check_status("t3 status", 32'h0000_0086);

        // Test 4: RX back-pressure.
        write_ctrl(32'h1);
        repeat (15) @(negedge clk);
        check_status("t4 rx full", 32'h0000_0809);
        write_sample(8'h40, sext_model(8'h40), 1'b0);
        write_sample(8'hC0, sext_model(8'hC0), 1'b0);
        repeat (5) @(negedge clk);
        check_status("t4 stalled", 32'h0000_0828);
        check("t4 dpcm_in held", {24'b0, dpcm_in}, 32'h17);
        read_result("t4 data_out");
        repeat (5) @(negedge clk);
        check_status("t4 one freed", 32'h0000_0818);
        check("t4 dpcm_in next", {24'b0, dpcm_in}, 32'h40);
        read_result("t4 data_out");
        repeat (5) @(negedge clk);
        check_status("t4 two freed", 32'h0000_0809);
        for (int k = 0; k < 8; k++) read_result("t4 data_out");
        check_status("t4 drained", 32'h0000_0005);

        // Test 5: reset with two samples in flight and three queued.
        write_ctrl(32'h0);
        for (int i = 0; i < 5; i++)
            write_sample(8'h21 + 8'(i), sext_model(8'h21 + 8'(i)), 1'b0);
        write_ctrl(32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5 reset dpcm_in", {24'b0, dpcm_in}, 32'd0);
        check("t5 reset irq",     {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check_status("t5 after reset", 32'h0000_0005);
        apb_read(A_CTRL, d, e);
        check("t5 ctrl cleared", d, 32'd0);
        check("t5 dpcm_in idle", {24'b0, dpcm_in}, 32'd0);

        // Test 6: interrupt, then flush.
        write_ctrl(32'h3);
        check("t6 irq idle", {31'b0, irq}, 32'd0);
        write_sample(8'h33, sext_model(8'h33), 1'b0);
        repeat (6) @(negedge clk);
        check("t6 irq set", {31'b0, irq}, 32'd1);
        read_result("t6 data_out");
        @(negedge clk);
        check("t6 irq cleared", {31'b0, irq}, 32'd0);
        write_sample(8'h01, sext_model(8'h01), 1'b0);
        write_sample(8'h02, sext_model(8'h02), 1'b0);
        repeat (6) @(negedge clk);
        write_ctrl(32'h2);
        write_sample(8'h03, sext_model(8'h03), 1'b0);
        write_sample(8'h04, sext_model(8'h04), 1'b0);
        write_sample(8'h05, sext_model(8'h05), 1'b0);
        check_status("t6 before flush", 32'h0000_0230);
        check("t6 irq pending", {31'b0, irq}, 32'd1);
        write_ctrl(32'h4);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_status("t6 after flush", 32'h0000_0005);
        apb_read(A_CTRL, d, e);
        check("t6 flush self-clear", d, 32'd0);
        check("t6 irq after flush", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
